fifo_rd_sched: RTL and testbench
================================

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 Parameter ADDRSIZE, 6, FIFO address width; depth = 2**ADDRSIZE.
REQ-002 Parameter DSIZE, 8, data word width.
REQ-003 Parameter NREQ, 4, number of read requesters, 2..8.
REQ-004 Parameter BURST, 4, max words per grant, 1..16.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 rclk  input  1  read-domain clock; all state on rising edge.
REQ-007 rrst_n  input  1  synchronous active-low reset.
REQ-008 rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already 2-flop synchronized into rclk.
REQ-009 rdata  input  DSIZE  memory word at raddr, valid combinationally in the same cycle.
REQ-010 req  input  NREQ  per-requester level read request.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
REQ-013 rptr  output  ADDRSIZE+1  registered Gray read pointer to write domain.
REQ-014 rempty  output  1  registered FIFO-empty flag.
REQ-015 rlevel  output  ADDRSIZE+1  combinational occupancy = gray2bin(rq2_wptr) - rbin, modulo 2**(ADDRSIZE+1).
REQ-016 out_valid, out_data (DSIZE), out_id ($clog2(NREQ)) outputs: registered delivered word and owning requester.

Function
REQ-017 pop = (state==SERVE) & req[owner] & ~rempty & (~out_valid | out_ready); single cycle, one word per pop.
REQ-018 On pop: rbin <= rbin+1 (wraps at 2**(ADDRSIZE+1)); rptr <= Gray(rbin+1) = (n>>1)^n.
REQ-019 rempty <= (Gray(rbin_next) == rq2_wptr), with rbin_next = rbin+pop; evaluated every cycle.
REQ-020 On pop: out_data <= rdata, out_id <= owner, out_valid <= 1; latency pop-to-out_valid = 1 cycle.
REQ-021 No pop and out_ready=1: out_valid <= 0; no pop and out_ready=0: out_valid, out_data, out_id hold.
REQ-022 FSM states IDLE, SERVE; owner register $clog2(NREQ) bits; last register = previous owner; cnt 0..BURST.
REQ-023 IDLE -> SERVE when |req & ~rempty: owner <= first asserted req searching last+1, last+2, ... wrapping modulo NREQ; cnt <= 0.
REQ-024 IDLE otherwise holds; no pop in IDLE (one dead cycle per grant change).
REQ-025 SERVE: each pop increments cnt; pop making cnt==BURST -> IDLE, last <= owner.
REQ-026 SERVE with req[owner]=0 -> IDLE, last <= owner, no pop.
REQ-027 SERVE with rempty=1 -> IDLE, last <= owner, no pop.
REQ-028 SERVE with output stalled (out_valid & ~out_ready) and req[owner]=1 and ~rempty: hold SERVE, cnt holds.
REQ-029 Requester changing req while not owner has no effect until next IDLE arbitration.
REQ-030 Never pop when rempty=1; never pop twice per cycle; out_data never overwritten while out_valid & ~out_ready.

Reset
REQ-031 rrst_n=0 at rising edge, any state: rbin=0, rptr=0, rempty=1, out_valid=0, out_data=0, out_id=0, state=IDLE, owner=0, cnt=0, last=NREQ-1.
REQ-032 Reset mid-burst discards the in-flight output word and burst count; first arbitration after reset favours requester 0.

Verification
REQ-033 Reset with rq2_wptr=0 -> rempty=1, rptr=0, out_valid=0, rlevel=0 next cycle.
REQ-034 rq2_wptr=Gray(3), req=4'b0010, out_ready=1 -> 1 IDLE cycle, pops addr 0,1,2 on 3 consecutive cycles, out_id=1, rempty=1 after third pop, state IDLE.
REQ-035 FIFO holds 16 words, req=4'b1111, BURST=4, out_ready=1 -> grant order 0,1,2,3, 4 words each, one dead cycle between bursts.
REQ-036 Owner 2 popping, out_ready=0 for 3 cycles -> out_data/out_id held, rbin unchanged, cnt unchanged; resumes on out_ready=1.
REQ-037 Push/pop 130 words with ADDRSIZE=6 -> rbin wraps 127->0, rptr Gray sequence single-bit changes, rlevel correct across wrap.
REQ-038 rrst_n=0 mid-burst with out_valid=1 -> all outputs at REQ-031 values next cycle; next grant to lowest asserted requester.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// Read side of an async FIFO with a round-robin burst scheduler: requesters
// take turns draining up to BURST words each, one registered word per pop.
module fifo_rd_sched #(
   parameter int ADDRSIZE = 6,
   parameter int DSIZE    = 8,
   parameter int NREQ     = 4,
   parameter int BURST    = 4
) (
   input  logic                       rclk,
   input  logic                       rrst_n,
   input  logic [ADDRSIZE:0]          rq2_wptr,
   input  logic [DSIZE-1:0]           rdata,
   input  logic [NREQ-1:0]            req,
   input  logic                       out_ready,
   output logic [ADDRSIZE-1:0]        raddr,
   output logic [ADDRSIZE:0]          rptr,
   output logic                       rempty,
   output logic [ADDRSIZE:0]          rlevel,
   output logic                       out_valid,
   output logic [DSIZE-1:0]           out_data,
   output logic [$clog2(NREQ)-1:0]    out_id
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(BURST + 1);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t              r_state;
   logic [IDW-1:0]      r_owner;
   logic [IDW-1:0]      r_last;
   logic [CW-1:0]       r_cnt;
   logic [ADDRSIZE:0]   r_rbin;
   logic [ADDRSIZE:0]   r_rptr;
   logic                r_rempty;
   logic                r_outValid;
   logic [DSIZE-1:0]    r_outData;
   logic [IDW-1:0]      r_outId;

   logic                w_pop;
   logic [ADDRSIZE:0]   w_rbinNext;
   logic [ADDRSIZE:0]   w_rgrayNext;
   logic [ADDRSIZE:0]   w_wbin;
   logic [CW-1:0]       w_cntNext;
   logic [IDW-1:0]      w_grantId;
   logic                w_found;

   assign w_pop       = (r_state == SERVE) & req[r_owner] & ~r_rempty &
                        (~r_outValid | out_ready);
   assign w_rbinNext  = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
   assign w_rgrayNext = (w_rbinNext >> 1) ^ w_rbinNext;
   assign w_cntNext   = r_cnt + CW'(1);

   // Gray-to-binary of the synchronized write pointer: each bit is the XOR of itself and all higher bits
   always_comb begin
      w_wbin = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         w_wbin[i] = ^(rq2_wptr >> i);
      end
   end

   // Round-robin search starting just after the previous owner
   always_comb begin
      w_grantId = '0;
      w_found   = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!w_found && req[(int'(r_last) + i) % NREQ]) begin
            w_found   = 1'b1;
            w_grantId = IDW'((int'(r_last) + i) % NREQ);
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_last     <= IDW'(NREQ - 1);
         r_cnt      <= '0;
         r_rbin     <= '0;
         r_rptr     <= '0;
         r_rempty   <= 1'b1;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outId    <= '0;
      end else begin
         r_rbin   <= w_rbinNext;
         r_rptr   <= w_rgrayNext;
         r_rempty <= (w_rgrayNext == rq2_wptr);

         if (w_pop) begin
            r_outValid <= 1'b1;
            r_outData  <= rdata;
            r_outId    <= r_owner;
         end else if (out_ready) begin
            r_outValid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_found && !r_rempty) begin
                  r_state <= SERVE;
                  r_owner <= w_grantId;
                  r_cnt   <= '0;
               end
            end
            SERVE: begin
               if (w_pop) begin
                  r_cnt <= w_cntNext;
                  if (w_cntNext == CW'(BURST)) begin
                     r_state <= IDLE;
                     r_last  <= r_owner;
                  end
               end else if (!req[r_owner] || r_rempty) begin
                  r_state <= IDLE;
                  r_last  <= r_owner;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign raddr     = r_rbin[ADDRSIZE-1:0];
   assign rptr      = r_rptr;
   assign rempty    = r_rempty;
   assign rlevel    = w_wbin - r_rbin;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_id    = r_outId;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: a behavioural write side fills a memory
// model and advances the Gray write pointer; outputs are checked after each edge.
module tb_fifo_rd_sched;

   logic         rclk;
   logic         rrst_n;
   logic [6:0]   rq2_wptr;
   logic [7:0]   rdata;
   logic [3:0]   req;
   logic         out_ready;
   logic [5:0]   raddr;
   logic [6:0]   rptr;
   logic         rempty;
   logic [6:0]   rlevel;
   logic         out_valid;
   logic [7:0]   out_data;
   logic [1:0]   out_id;

   logic [7:0]   mem [64];
   int           wbin;
   int           errorCount;
   int           checkCount;

   fifo_rd_sched #(.ADDRSIZE(6), .DSIZE(8), .NREQ(4), .BURST(4)) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rq2_wptr  (rq2_wptr),
      .rdata     (rdata),
      .req       (req),
      .out_ready (out_ready),
      .raddr     (raddr),
      .rptr      (rptr),
      .rempty    (rempty),
      .rlevel    (rlevel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   assign rdata = mem[raddr];

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   function automatic logic [6:0] toGray(input logic [6:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Value written for the n-th word pushed since the last reset
   function automatic int wv(input int n);
      return (n * 37 + 5) & 8'hFF;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge rclk);
         #1;
      end
   endtask

   task automatic pushWord();
      mem[wbin % 64] = 8'(wv(wbin));
      wbin++;
      rq2_wptr = toGray(7'(wbin));
   endtask

   task automatic resetDut();
      rrst_n    = 1'b0;
      wbin      = 0;
      rq2_wptr  = '0;
      req       = '0;
      out_ready = 1'b1;
      applyStimulus(2);
      rrst_n    = 1'b1;
   endtask

   initial begin
      int idx;
      int popCount;
      logic [6:0] prevRptr;
      errorCount = 0;
      checkCount = 0;
      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset state
      resetDut();
      checkOutput("rstEmpty", int'(rempty), 1);
      checkOutput("rstRptr", int'(rptr), 0);
      checkOutput("rstValid", int'(out_valid), 0);
      checkOutput("rstLevel", int'(rlevel), 0);
      checkOutput("rstData", int'(out_data), 0);
      checkOutput("rstId", int'(out_id), 0);
      applyStimulus(1);
      checkOutput("postRstEmpty", int'(rempty), 1);

      // Three words, single requester 1
      resetDut();
      repeat (3) pushWord();
      req = 4'b0010;
      applyStimulus(1);
      checkOutput("t3Empty", int'(rempty), 0);
      applyStimulus(1);
      checkOutput("t3IdleValid", int'(out_valid), 0);
      checkOutput("t3IdleAddr", int'(raddr), 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1);
         checkOutput("t3Valid", int'(out_valid), 1);
         checkOutput("t3Data", int'(out_data), wv(k));
         checkOutput("t3Id", int'(out_id), 1);
      end
      checkOutput("t3EmptyEnd", int'(rempty), 1);
      checkOutput("t3Rptr", int'(rptr), 2);
      checkOutput("t3Level", int'(rlevel), 0);
      checkOutput("t3Addr", int'(raddr), 3);
      applyStimulus(1);
      checkOutput("t3Drained", int'(out_valid), 0);

      // Sixteen words, all requesters: bursts of 4 with one dead cycle between
      resetDut();
      repeat (16) pushWord();
      req = 4'b1111;
      applyStimulus(2);
      checkOutput("rrIdle", int'(out_valid), 0);
      idx = 0;
      for (int k = 1; k <= 19; k++) begin
         applyStimulus(1);
         if (k % 5 == 0) begin
            checkOutput("rrGap", int'(out_valid), 0);
         end else begin
            checkOutput("rrValid", int'(out_valid), 1);
            checkOutput("rrId", int'(out_id), k / 5);
            checkOutput("rrData", int'(out_data), wv(idx));
            idx++;
         end
      end
      checkOutput("rrEmpty", int'(rempty), 1);

      // Output stall during owner 2's burst
      resetDut();
      repeat (8) pushWord();
      req = 4'b0100;
      applyStimulus(3);
      checkOutput("stFirst", int'(out_data), wv(0));
      checkOutput("stFirstId", int'(out_id), 2);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1);
         checkOutput("stHoldValid", int'(out_valid), 1);
         checkOutput("stHoldData", int'(out_data), wv(0));
         checkOutput("stHoldId", int'(out_id), 2);
         checkOutput("stHoldAddr", int'(raddr), 1);
         checkOutput("stHoldLevel", int'(rlevel), 7);
      end
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1);
         checkOutput("stResume", int'(out_data), wv(k));
      end
      applyStimulus(1);
      checkOutput("stBurstEnd", int'(out_valid), 0);
      applyStimulus(1);
      checkOutput("stRegrant", int'(out_data), wv(4));
      checkOutput("stRegrantId", int'(out_id), 2);

      // 130 words streamed through a 64-deep FIFO: pointer wrap
      resetDut();
      req = 4'b0001;
      popCount = 0;
      prevRptr = rptr;
      for (int cyc = 0; cyc < 1000 && popCount < 130; cyc++) begin
         if (wbin < 130 && (wbin - popCount) < 60) pushWord();
         applyStimulus(1);
         if (out_valid) begin
            popCount++;
            checkOutput("wrapData", int'(out_data), wv(popCount - 1));
         end
         checkOutput("wrapRptr", int'(rptr), int'(toGray(7'(popCount))));
         checkOutput("wrapGrayStep", int'($countones(rptr ^ prevRptr) <= 1), 1);
         checkOutput("wrapLevel", int'(rlevel), (wbin - popCount) & 8'h7F);
         prevRptr = rptr;
      end
      checkOutput("wrapDone", popCount, 130);
      checkOutput("wrapEndRptr", int'(rptr), 3);
      checkOutput("wrapEndEmpty", int'(rempty), 1);

      // Reset in the middle of owner 3's burst
      resetDut();
      repeat (8) pushWord();
      req = 4'b1010;
      applyStimulus(6);
      checkOutput("mrOwner1", int'(out_id), 1);
      checkOutput("mrData1", int'(out_data), wv(3));
      applyStimulus(2);
      checkOutput("mrValid3", int'(out_valid), 1);
      checkOutput("mrOwner3", int'(out_id), 3);
      checkOutput("mrData3", int'(out_data), wv(4));
      rrst_n = 1'b0;
      applyStimulus(1);
      checkOutput("mrValid", int'(out_valid), 0);
      checkOutput("mrOutData", int'(out_data), 0);
      checkOutput("mrOutId", int'(out_id), 0);
      checkOutput("mrRptr", int'(rptr), 0);
      checkOutput("mrEmpty", int'(rempty), 1);
      checkOutput("mrAddr", int'(raddr), 0);
      rrst_n = 1'b1;
      applyStimulus(2);
      checkOutput("mrIdle", int'(out_valid), 0);
      applyStimulus(1);
      checkOutput("mrGrantValid", int'(out_valid), 1);
      checkOutput("mrGrantId", int'(out_id), 1);
      checkOutput("mrGrantData", int'(out_data), wv(0));

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
